mac_vec_pipe: RTL and testbench
===============================

Name: mac_vec_pipe

Overview:
Pipelined, parametrised multiply-accumulate unit for the MPU datapath. It is the multi-lane successor to the scalar behavioural MAC.
- Each beat multiplies LANES signed operand pairs and reduces them in an adder tree.
- The sum is added into one signed accumulator.
- The accumulator supports bias preload, optional saturation and a sticky overflow flag.
- It sits between the operand fetch and the result writeback of the systolic/vector path.

Parameters:
VAR_SIZE, 8, signed operand width per lane
ACC_SIZE, 32, signed accumulator width; must be >= 2*VAR_SIZE + $clog2(LANES) (elaboration-time assertion)
LANES, 4, number of parallel products per beat; power of two, >= 1

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  beat carries valid a/b operands
clear  in  1  start of new dot product: accumulator restarts from bias
a  in  LANES*VAR_SIZE  packed signed operands, lane i = a[i*VAR_SIZE +: VAR_SIZE]
b  in  LANES*VAR_SIZE  packed signed operands, same packing
bias  in  ACC_SIZE  signed preload value, sampled with clear
sat_en  in  1  1 = saturate accumulator, 0 = two's-complement wrap; sampled at stage 3
acc  out  ACC_SIZE  signed accumulator value
acc_valid  out  1  one-cycle pulse when acc was updated
overflow  out  1  sticky signed-overflow flag
busy  out  1  any token in stages 1-2

Behaviour:
Reset:
- rst_n low clears all pipeline registers, valid/clear tags, acc, acc_valid, overflow and busy to 0 immediately, without waiting for clk.
- In-flight tokens are discarded; no acc_valid is produced from them after release.

Pipeline (latency 3, throughput 1 beat/cycle, no backpressure):
- A token is in_valid | clear; only tokens advance tags. No handshake; the upstream may issue every cycle.
- Stage 1: register LANES products, each 2*VAR_SIZE signed. Register in_valid, clear and bias alongside them.
- Stage 2: adder tree sum, sign-extended to ACC_SIZE. A lane contributes 0 when the token's in_valid=0.
- Stage 3: base = clear_tag ? bias_tag : acc. Compute next = base + sum at ACC_SIZE+1 bits.
  - Signed overflow: the top two bits of next differ.
  - On overflow with sat_en=1: acc clamps to +max or -min according to the sign of next.
  - On overflow with sat_en=0: acc takes the low ACC_SIZE bits (wrap).
  - overflow is set on any stage-3 overflow regardless of sat_en. A clear token first resets it, then it is set again if that same clear beat overflows.
- acc_valid=1 in the cycle after a stage-3 update; otherwise 0.
- Without a token, acc holds its value.

Boundary conditions:
- clear with in_valid=0: acc = bias, acc_valid pulses.
- Back-to-back clears: each result is independent.
- Extreme operands (-2^(VAR_SIZE-1) squared) must not overflow the product or tree width.

Decomposition:
- Package mpu_pkg:
  - defaults VAR_SIZE_D and ACC_SIZE_D;
  - function sat_clamp(ACC_SIZE+1 value) returning the clamped value and overflow;
  - typedef for the stage token struct {valid, clear, bias}.
- One sub-module, add_tree: parametrised LANES-input signed combinational reduction, used in stage 2.

Test Plan:
- Reset: assert rst_n low between edges while 2 tokens are in flight -> acc=0, acc_valid=0, overflow=0 at once; no acc_valid pulse after release.
- Bias load (LANES=4, VAR_SIZE=8, ACC_SIZE=32): clear=1, in_valid=1, bias=-9, a={1,2,3,4}, b={5,6,7,8}.
  - 3 cycles later: acc=61, acc_valid=1.
  - Next beat a=all -128, b=all 127: acc=61-65024=-64963.
- Bubbles: in_valid=0, clear=0 for 5 cycles -> acc holds -64963, acc_valid stays 0, busy drops 2 cycles after the last token.
- Saturation (ACC_SIZE=18): clear, bias=0, two beats of a=all -128, b=all -128 (65536 each).
  - sat_en=1 -> acc=131071, overflow=1.
  - Repeat with sat_en=0 -> acc=-131072, overflow=1.
  - A following clear with bias=5 and no overflow -> overflow=0, acc=5+sum.
- Back-to-back clears: clear on 3 consecutive beats with bias=1,2,3, a=b=all 1 -> acc sequence 5, 6, 7, with acc_valid high for 3 cycles.
- Random: 200 cycles of random a, b, bias in [-9,9], clear and in_valid against a reference model -> every acc_valid cycle matches, and overflow matches exactly.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared types and helpers for the MPU multiply-accumulate datapath.
// Holds default widths, the stage token payload and the accumulator clamp.
package mpu_pkg;

    localparam int unsigned VAR_SIZE_D = 8;
    localparam int unsigned ACC_SIZE_D = 32;
    localparam int unsigned LANES_D    = 4;

    // Widest accumulator the shared helpers can serve; CLAMP_W holds one guard bit.
    localparam int unsigned ACC_MAX_W = 64;
    localparam int unsigned CLAMP_W   = ACC_MAX_W + 1;

    // Per-stage tag travelling with each beat; bias is kept sign-extended.
    typedef struct packed {
        logic                 valid;
        logic                 clear;
        logic [ACC_MAX_W-1:0] bias;
    } tok_t;

    typedef struct packed {
        logic                 ovf;
        logic [ACC_MAX_W-1:0] value;
    } sat_res_t;

    // nxt is an acc_w+1 bit signed sum, sign-extended to CLAMP_W.
    // Returns the wrapped or saturated result (sign-extended) and the overflow bit.
    function automatic sat_res_t sat_clamp(input logic [CLAMP_W-1:0] nxt,
                                           input int unsigned        acc_w,
                                           input logic               sat_en);
        sat_res_t             r;
        logic                 top;
        logic                 sec;
        logic [ACC_MAX_W-1:0] lo_mask;
        top     = 1'(nxt >> acc_w);
        sec     = 1'(nxt >> (acc_w - 1));
        lo_mask = {ACC_MAX_W{1'b1}} >> (ACC_MAX_W - acc_w + 1);
        r.ovf   = top ^ sec;
        r.value = (r.ovf && sat_en) ? (top ? ~lo_mask : lo_mask) : nxt[ACC_MAX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/add_tree.sv
// Combinational signed reduction of LANES packed operands as a balanced binary tree.
// Output carries $clog2(LANES) growth bits so no input combination can overflow.
module add_tree #(
    parameter int unsigned LANES = 4,
    parameter int unsigned IW    = 16
) (
    input  logic [LANES*IW-1:0]             din,
    output logic [IW+$clog2(LANES)-1:0]     sum
);

    localparam int unsigned OW = IW + $clog2(LANES);

    // Heap-ordered nodes: leaves at LANES-1 .. 2*LANES-2, root at 0.
    for (genvar j = 0; j < 2*LANES-1; j++) begin : g_node
        logic signed [OW-1:0] v;
        if (j >= LANES-1) begin : g_leaf
            assign v = OW'(signed'(din[(j-LANES+1)*IW +: IW]));
        end else begin : g_sum
            assign v = g_node[2*j+1].v + g_node[2*j+2].v;
        end
    end

    assign sum = g_node[0].v;

endmodule

// File: rtl/mac_vec_pipe.sv
// Three-stage multi-lane signed multiply-accumulate: products, adder tree, accumulate.
// Accumulator supports bias preload, optional saturation and a sticky overflow flag.
module mac_vec_pipe
    import mpu_pkg::*;
#(
    parameter int unsigned VAR_SIZE = VAR_SIZE_D,
    parameter int unsigned ACC_SIZE = ACC_SIZE_D,
    parameter int unsigned LANES    = LANES_D
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      clear,
    input  logic [LANES*VAR_SIZE-1:0] a,
    input  logic [LANES*VAR_SIZE-1:0] b,
    input  logic [ACC_SIZE-1:0]       bias,
    input  logic                      sat_en,
    output logic [ACC_SIZE-1:0]       acc,
    output logic                      acc_valid,
    output logic                      overflow,
    output logic                      busy
);

    localparam int unsigned PW = 2 * VAR_SIZE;
    localparam int unsigned TW = PW + $clog2(LANES);

    if (ACC_SIZE < TW) begin : g_acc_too_narrow
        $error("mac_vec_pipe: ACC_SIZE must be >= 2*VAR_SIZE + clog2(LANES)");
    end
    if (ACC_SIZE >= ACC_MAX_W + 1) begin : g_acc_too_wide
        $error("mac_vec_pipe: ACC_SIZE exceeds mpu_pkg::ACC_MAX_W");
    end
    if ((LANES == 0) || ((LANES & (LANES - 1)) != 0)) begin : g_lanes_not_pow2
        $error("mac_vec_pipe: LANES must be a power of two");
    end

    logic [LANES*PW-1:0]  prod_c;
    logic [LANES*PW-1:0]  prod_q;
    logic [LANES*PW-1:0]  tree_in;
    logic [TW-1:0]        tree_sum;
    logic [ACC_SIZE-1:0]  sum2_q;
    tok_t                 tok1_q;
    tok_t                 tok2_q;
    logic                 t1;
    logic                 t2;
    logic [CLAMP_W-1:0]   base_w;
    logic [CLAMP_W-1:0]   next_w;
    sat_res_t             clamp_c;

    assign t1 = tok1_q.valid | tok1_q.clear;
    assign t2 = tok2_q.valid | tok2_q.clear;

    // Stage 1 operands: full-width signed products, exact even for (-2^(V-1))^2.
    for (genvar i = 0; i < LANES; i++) begin : g_mul
        assign prod_c[i*PW +: PW] = PW'(signed'(a[i*VAR_SIZE +: VAR_SIZE]))
                                  * PW'(signed'(b[i*VAR_SIZE +: VAR_SIZE]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q       <= '0;
            tok1_q       <= '0;
        end else begin
            tok1_q.valid <= in_valid;
            tok1_q.clear <= clear;
            if (clear) begin
                tok1_q.bias <= ACC_MAX_W'(signed'(bias));
            end
            if (in_valid) begin
                prod_q <= prod_c;
            end
        end
    end

    // Clear-only tokens reduce to zero so the accumulator lands exactly on bias.
    assign tree_in = tok1_q.valid ? prod_q : '0;

    add_tree #(
        .LANES (LANES),
        .IW    (PW)
    ) u_add_tree (
        .din   (tree_in),
        .sum   (tree_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum2_q <= '0;
            tok2_q <= '0;
        end else begin
            tok2_q <= tok1_q;
            if (t1) begin
                sum2_q <= ACC_SIZE'(signed'(tree_sum));
            end
        end
    end

    // Stage 3 arithmetic is done sign-extended; overflow is judged at ACC_SIZE+1 bits.
    always_comb begin
        base_w  = tok2_q.clear ? CLAMP_W'(signed'(tok2_q.bias)) : CLAMP_W'(signed'(acc));
        next_w  = base_w + CLAMP_W'(signed'(sum2_q));
        clamp_c = sat_clamp(next_w, ACC_SIZE, sat_en);
    end

    if (ACC_SIZE < ACC_MAX_W) begin : g_clamp_hi
        logic unused_clamp_hi;
        assign unused_clamp_hi = ^clamp_c.value[ACC_MAX_W-1:ACC_SIZE];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            acc_valid <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            acc_valid <= t2;
            busy      <= in_valid | clear | t1;
            if (t2) begin
                acc      <= clamp_c.value[ACC_SIZE-1:0];
                overflow <= (tok2_q.clear ? 1'b0 : overflow) | clamp_c.ovf;
            end
        end
    end

endmodule

// File: tb/tb_mac_vec_pipe.sv
// Directed and randomised checks of mac_vec_pipe at ACC_SIZE=32 plus a narrow
// ACC_SIZE=18 instance sharing the same stimulus for saturation/wrap behaviour.
module tb_mac_vec_pipe;

    localparam int unsigned VS   = 8;
    localparam int unsigned LN   = 4;
    localparam int unsigned AW   = 32;
    localparam int unsigned AW_S = 18;
    localparam longint      LMAX = 64'sd2147483647;
    localparam longint      LMIN = -LMAX - 64'sd1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 clear;
    logic                 sat_en;
    logic [LN*VS-1:0]     a;
    logic [LN*VS-1:0]     b;
    logic [AW-1:0]        bias;
    logic [AW_S-1:0]      bias_s;
    logic [AW-1:0]        acc;
    logic                 acc_valid;
    logic                 overflow;
    logic                 busy;
    logic [AW_S-1:0]      acc_s;
    logic                 acc_valid_s;
    logic                 overflow_s;
    logic                 busy_s;

    int n_checks = 0;
    int n_pass   = 0;

    assign bias_s = bias[AW_S-1:0];

    always #5 clk = ~clk;

    mac_vec_pipe #(.VAR_SIZE(VS), .ACC_SIZE(AW), .LANES(LN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .clear(clear),
        .a(a), .b(b), .bias(bias), .sat_en(sat_en),
        .acc(acc), .acc_valid(acc_valid), .overflow(overflow), .busy(busy)
    );

    mac_vec_pipe #(.VAR_SIZE(VS), .ACC_SIZE(AW_S), .LANES(LN)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .clear(clear),
        .a(a), .b(b), .bias(bias_s), .sat_en(sat_en),
        .acc(acc_s), .acc_valid(acc_valid_s), .overflow(overflow_s), .busy(busy_s)
    );

    function automatic logic [LN*VS-1:0] pack4(input int l0, input int l1,
                                               input int l2, input int l3);
        return {VS'(l3), VS'(l2), VS'(l1), VS'(l0)};
    endfunction

    function automatic logic [LN*VS-1:0] fill(input int x);
        return pack4(x, x, x, x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic c, input int bv,
                         input logic [LN*VS-1:0] av, input logic [LN*VS-1:0] bw);
        in_valid = v;
        clear    = c;
        bias     = AW'(bv);
        a        = av;
        b        = bw;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, '0, '0);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        sat_en = 1'b0;
        idle();
        tick();
        tick();
        n_checks++; if (acc !== '0) $display("FAIL por_acc: got %0d want 0", acc); else n_pass++;
        n_checks++; if (acc_valid !== 1'b0) $display("FAIL por_acc_valid: got %b want 0", acc_valid); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL por_overflow: got %b want 0", overflow); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL por_busy: got %b want 0", busy); else n_pass++;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 100, '0, '0);
        tick();
        idle();
        tick();
        tick();
        n_checks++; if (acc !== AW'(100)) $display("FAIL rst_pre_acc: got %0d want 100", $signed(acc)); else n_pass++;
        n_checks++; if (acc_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", acc_valid); else n_pass++;
        drive(1'b1, 1'b1, 7, fill(1), fill(1));
        tick();
        drive(1'b1, 1'b0, 0, fill(2), fill(2));
        tick();
        idle();
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", busy); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (acc !== '0) $display("FAIL rst_async_acc: got %0d want 0", $signed(acc)); else n_pass++;
        n_checks++; if (acc_valid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", acc_valid); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rst_async_ovf: got %b want 0", overflow); else n_pass++;
        n_checks++; if (busy !== 1'b0 || busy_s !== 1'b0) $display("FAIL rst_async_busy: got %b/%b want 0/0", busy, busy_s); else n_pass++;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (acc_valid !== 1'b0) $display("FAIL rst_flush_valid[%0d]: got %b want 0", i, acc_valid); else n_pass++;
        end
        n_checks++; if (acc !== '0) $display("FAIL rst_flush_acc: got %0d want 0", $signed(acc)); else n_pass++;
    endtask

    task automatic test_bias_load();
        drive(1'b1, 1'b1, -9, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
        tick();
        drive(1'b1, 1'b0, 0, fill(-128), fill(127));
        tick();
        idle();
        tick();
        n_checks++; if (acc !== AW'(61)) $display("FAIL bias_acc: got %0d want 61", $signed(acc)); else n_pass++;
        n_checks++; if (acc_valid !== 1'b1) $display("FAIL bias_valid: got %b want 1", acc_valid); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL bias_busy: got %b want 1", busy); else n_pass++;
        tick();
        n_checks++; if (acc !== AW'(-64963)) $display("FAIL extreme_acc: got %0d want -64963", $signed(acc)); else n_pass++;
        n_checks++; if (acc_valid !== 1'b1) $display("FAIL extreme_valid: got %b want 1", acc_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL busy_drop: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_bubbles();
        idle();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (acc !== AW'(-64963)) $display("FAIL bubble_acc[%0d]: got %0d want -64963", i, $signed(acc)); else n_pass++;
            n_checks++; if (acc_valid !== 1'b0) $display("FAIL bubble_valid[%0d]: got %b want 0", i, acc_valid); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL bubble_busy[%0d]: got %b want 0", i, busy); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        sat_en = 1'b1;
        drive(1'b1, 1'b1, 0, fill(-128), fill(-128));
        tick();
        drive(1'b1, 1'b0, 0, fill(-128), fill(-128));
        tick();
        idle();
        tick();
        n_checks++; if (acc_s !== AW_S'(65536)) $display("FAIL sat_first: got %0d want 65536", $signed(acc_s)); else n_pass++;
        n_checks++; if (overflow_s !== 1'b0) $display("FAIL sat_first_ovf: got %b want 0", overflow_s); else n_pass++;
        tick();
        n_checks++; if (acc_s !== AW_S'(131071)) $display("FAIL sat_clamp: got %0d want 131071", $signed(acc_s)); else n_pass++;
        n_checks++; if (overflow_s !== 1'b1) $display("FAIL sat_ovf: got %b want 1", overflow_s); else n_pass++;
        n_checks++; if (acc_valid_s !== 1'b1) $display("FAIL sat_valid: got %b want 1", acc_valid_s); else n_pass++;
        sat_en = 1'b0;
        drive(1'b1, 1'b1, 0, fill(-128), fill(-128));
        tick();
        drive(1'b1, 1'b0, 0, fill(-128), fill(-128));
        tick();
        idle();
        tick();
        n_checks++; if (overflow_s !== 1'b0) $display("FAIL wrap_clear_ovf: got %b want 0", overflow_s); else n_pass++;
        tick();
        n_checks++; if (acc_s !== AW_S'(-131072)) $display("FAIL wrap_acc: got %0d want -131072", $signed(acc_s)); else n_pass++;
        n_checks++; if (overflow_s !== 1'b1) $display("FAIL wrap_ovf: got %b want 1", overflow_s); else n_pass++;
        drive(1'b1, 1'b1, 5, fill(1), fill(1));
        tick();
        idle();
        tick();
        tick();
        n_checks++; if (acc_s !== AW_S'(9)) $display("FAIL clr_after_ovf_acc: got %0d want 9", $signed(acc_s)); else n_pass++;
        n_checks++; if (overflow_s !== 1'b0) $display("FAIL clr_after_ovf_flag: got %b want 0", overflow_s); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL wide_no_ovf: got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1, fill(1), fill(1));
        tick();
        drive(1'b1, 1'b1, 2, fill(1), fill(1));
        tick();
        drive(1'b1, 1'b1, 3, fill(1), fill(1));
        tick();
        idle();
        n_checks++; if (acc !== AW'(5) || acc_valid !== 1'b1) $display("FAIL b2b_0: got %0d/%b want 5/1", $signed(acc), acc_valid); else n_pass++;
        tick();
        n_checks++; if (acc !== AW'(6) || acc_valid !== 1'b1) $display("FAIL b2b_1: got %0d/%b want 6/1", $signed(acc), acc_valid); else n_pass++;
        tick();
        n_checks++; if (acc !== AW'(7) || acc_valid !== 1'b1) $display("FAIL b2b_2: got %0d/%b want 7/1", $signed(acc), acc_valid); else n_pass++;
        tick();
        n_checks++; if (acc !== AW'(7) || acc_valid !== 1'b0) $display("FAIL b2b_end: got %0d/%b want 7/0", $signed(acc), acc_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic               ev [3];
        longint             ea [3];
        logic               eo [3];
        longint             macc;
        logic               movf;
        logic               v;
        logic               c;
        int                 bv;
        logic [LN*VS-1:0]   av;
        logic [LN*VS-1:0]   bw;
        logic signed [VS-1:0] la;
        logic signed [VS-1:0] lb;
        longint             sum;
        longint             nxt;
        logic               ovf;
        for (int k = 0; k < 3; k++) begin
            ev[k] = 1'b0;
            ea[k] = 0;
            eo[k] = 1'b0;
        end
        macc   = 7;
        movf   = 1'b0;
        sat_en = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            v  = ($urandom_range(3, 0) != 0);
            c  = (cyc == 0) || ($urandom_range(7, 0) == 0);
            bv = int'($urandom_range(18, 0)) - 9;
            av = $urandom;
            bw = $urandom;
            drive(v, c, bv, av, bw);
            if (v || c) begin
                sum = 0;
                if (v) begin
                    for (int i = 0; i < int'(LN); i++) begin
                        la  = av[i*VS +: VS];
                        lb  = bw[i*VS +: VS];
                        sum = sum + longint'(la) * longint'(lb);
                    end
                end
                nxt  = (c ? longint'(bv) : macc) + sum;
                ovf  = (nxt > LMAX) || (nxt < LMIN);
                movf = (c ? 1'b0 : movf) | ovf;
                macc = longint'(int'(nxt));
            end
            tick();
            ev[2] = ev[1]; ea[2] = ea[1]; eo[2] = eo[1];
            ev[1] = ev[0]; ea[1] = ea[0]; eo[1] = eo[0];
            ev[0] = v || c; ea[0] = macc; eo[0] = movf;
            n_checks++; if (acc_valid !== ev[2]) $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, acc_valid, ev[2]); else n_pass++;
            if (ev[2]) begin
                n_checks++; if (acc !== AW'(ea[2])) $display("FAIL rnd_acc[%0d]: got %0d want %0d", cyc, $signed(acc), ea[2]); else n_pass++;
            end
            n_checks++; if (overflow !== eo[2]) $display("FAIL rnd_ovf[%0d]: got %b want %b", cyc, overflow, eo[2]); else n_pass++;
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_bias_load();
        test_bubbles();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
